// File: rtl/toast_branch_if.sv
// toast_branch_if: EX-stage control-transfer bundle between the pipeline (master) and toast_branch_ctrl (slave)
interface toast_branch_if;
  logic        valid_i;
  logic        stall_i;
  logic [1:0]  branch_op_i;
  logic        is_jump_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        busy_o;
  logic        misalign_o;
  logic [31:0] link_addr_o;
  logic [31:0] branch_count_o;
  logic [31:0] taken_count_o;
  modport master (
    output valid_i, stall_i, branch_op_i, is_jump_i, funct3_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    input  redirect_o, redirect_pc_o, flush_o, busy_o, misalign_o, link_addr_o, branch_count_o, taken_count_o
  );
  modport slave (
    input  valid_i, stall_i, branch_op_i, is_jump_i, funct3_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    output redirect_o, redirect_pc_o, flush_o, busy_o, misalign_o, link_addr_o, branch_count_o, taken_count_o
  );
endinterface

// File: rtl/toast_branch_ctrl.sv
// toast_branch_ctrl: EX-stage branch/JAL/JALR resolver with registered redirect and timed front-end flush; perf counters under TOAST_BRANCH_PERF_EN
`ifndef PC_RELATIVE
`define PC_RELATIVE 2'b01
`endif
`ifndef REG_OFFSET
`define REG_OFFSET 2'b10
`endif
module toast_branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk_i,
  input logic           resetn_i,
  toast_branch_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        legal, eval, eq, lt, ltu, cond, taken;
  logic [31:0] target;
  assign legal = (bus.branch_op_i == `PC_RELATIVE) || (bus.branch_op_i == `REG_OFFSET);
  assign eval = bus.valid_i && !bus.stall_i && state == IDLE && legal;
  assign target = bus.branch_op_i == `REG_OFFSET ? (bus.rs1_data_i + bus.imm_i) & 32'hFFFF_FFFE : bus.pc_i + bus.imm_i;
  assign eq = bus.rs1_data_i == bus.rs2_data_i;
  assign lt = $signed(bus.rs1_data_i) < $signed(bus.rs2_data_i);
  assign ltu = bus.rs1_data_i < bus.rs2_data_i;
  assign taken = bus.is_jump_i || cond;
  assign bus.busy_o = state == FLUSH;
  assign bus.flush_o = state == FLUSH;
  assign bus.link_addr_o = bus.pc_i + 32'd4;
  // branch condition from funct3; bit 0 inverts the base compare, 010/011 never taken
  always_comb begin
    cond = bus.funct3_i[2:1] == 2'b00 ? eq ^ bus.funct3_i[0] :
           bus.funct3_i[2:1] == 2'b10 ? lt ^ bus.funct3_i[0] :
           bus.funct3_i[2:1] == 2'b11 ? ltu ^ bus.funct3_i[0] : 1'b0;
  end
  // next state: enter FLUSH on an aligned taken transfer, count down only while not stalled
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE) begin
      if (eval && taken && !target[1]) begin
        state_nx = FLUSH;
        cnt_nx = 3'(FLUSH_CYCLES - 1);
      end
    end else if (!bus.stall_i) begin
      if (cnt == 3'd0) state_nx = IDLE;
      else cnt_nx = cnt - 3'd1;
    end
  end
  // FSM state and flush counter
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // one-cycle redirect/misalign strobes; target is captured only when a redirect is issued
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      bus.redirect_o <= 1'b0;
      bus.redirect_pc_o <= '0;
      bus.misalign_o <= 1'b0;
    end else begin
      bus.redirect_o <= eval && taken && !target[1];
      bus.misalign_o <= eval && taken && target[1];
      if (eval && taken && !target[1]) bus.redirect_pc_o <= target;
    end
  end
`ifdef TOAST_BRANCH_PERF_EN
  // perf counters: every evaluated transfer, and the taken ones (misaligned included)
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      bus.branch_count_o <= '0;
      bus.taken_count_o <= '0;
    end else begin
      if (eval) bus.branch_count_o <= bus.branch_count_o + 32'd1;
      if (eval && taken) bus.taken_count_o <= bus.taken_count_o + 32'd1;
    end
  end
`else
  assign bus.branch_count_o = '0;
  assign bus.taken_count_o = '0;
`endif
endmodule
